// File: rtl/nios_simple_cpu_ocimem_ctrl.sv
// rtl/nios_simple_cpu_ocimem_ctrl.sv - OCI debug RAM shared between JTAG commands and the CPU debug slave
module nios_simple_cpu_ocimem_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    input  logic [3:0]        cpu_byteenable,
    output logic              cpu_waitrequest,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_readdatavalid,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              jtag_rd_valid,
    output logic              jtag_overrun
);

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_RDWAIT} state_t;

    state_t              state_q, state_d;
    logic                slot_wr_q, slot_wr_d;
    logic [31:0]         slot_data_q, slot_data_d;
    logic [ADDR_W-1:0]   mon_a_q, mon_a_d;
    logic [31:0]         mon_d_q, mon_d_d;
    logic                overrun_q, overrun_d;
    logic [31:0]         cpu_hold_q, cpu_hold_d;
    logic                cpu_rvalid_q, cpu_rvalid_d;

    logic [31:0]         mem [0:(1<<ADDR_W)-1];
    logic [31:0]         ram_q;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [31:0]         ram_wdata;
    logic [3:0]          ram_be;

    logic win_a, win_b, win_n, lose, any_cmd, can_take, queue;
    logic unused_jdo;

    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    // Command arbitration: _b beats action_a beats no_action_a; PEND drops everything.
    always_comb begin
        win_b    = take_action_ocimem_b;
        win_a    = take_action_ocimem_a & ~take_action_ocimem_b;
        win_n    = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
        lose     = (take_action_ocimem_a & take_action_ocimem_b) |
                   (take_no_action_ocimem_a & (take_action_ocimem_a | take_action_ocimem_b));
        any_cmd  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
        can_take = (state_q != S_PEND);
        queue    = can_take & (win_b | win_n | (win_a & jdo[34]));
    end

    // Next-state logic for the command slot, address/data monitors and CPU read return.
    always_comb begin
        state_d      = state_q;
        slot_wr_d    = slot_wr_q;
        slot_data_d  = slot_data_q;
        mon_a_d      = mon_a_q;
        mon_d_d      = mon_d_q;
        overrun_d    = overrun_q;
        cpu_hold_d   = cpu_rvalid_q ? ram_q : cpu_hold_q;
        cpu_rvalid_d = can_take & cpu_read & ~cpu_write;

        case (state_q)
            S_IDLE:   state_d = queue ? S_PEND : S_IDLE;
            S_PEND:   state_d = slot_wr_q ? S_IDLE : S_RDWAIT;
            S_RDWAIT: state_d = queue ? S_PEND : S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (queue) begin
            slot_wr_d   = win_b;
            slot_data_d = jdo[34:3];
        end

        if (state_q == S_PEND) begin
            mon_a_d = mon_a_q + ADDR_W'(1);
        end else if (win_a) begin
            mon_a_d = jdo[ADDR_W+16:17];
        end

        if (state_q == S_RDWAIT) begin
            mon_d_d = ram_q;
        end

        // A dropped command wins over a clear arriving in the same cycle.
        if (lose | (any_cmd & ~can_take)) begin
            overrun_d = 1'b1;
        end else if (can_take & win_a & jdo[35]) begin
            overrun_d = 1'b0;
        end
    end

    // Single RAM port: JTAG owns it during PEND, the CPU otherwise.
    always_comb begin
        if (state_q == S_PEND) begin
            ram_we    = slot_wr_q;
            ram_addr  = mon_a_q;
            ram_wdata = slot_data_q;
            ram_be    = 4'hF;
        end else begin
            ram_we    = cpu_write;
            ram_addr  = cpu_address;
            ram_wdata = cpu_writedata;
            ram_be    = cpu_byteenable;
        end
    end

    // Byte-enabled write with registered read; contents are never reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_be[i]) begin
                    mem[ram_addr][i*8 +: 8] <= ram_wdata[i*8 +: 8];
                end
            end
        end
        ram_q <= mem[ram_addr];
    end

    // Control and holding registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            slot_wr_q    <= 1'b0;
            slot_data_q  <= '0;
            mon_a_q      <= '0;
            mon_d_q      <= '0;
            overrun_q    <= 1'b0;
            cpu_hold_q   <= '0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_wr_q    <= slot_wr_d;
            slot_data_q  <= slot_data_d;
            mon_a_q      <= mon_a_d;
            mon_d_q      <= mon_d_d;
            overrun_q    <= overrun_d;
            cpu_hold_q   <= cpu_hold_d;
            cpu_rvalid_q <= cpu_rvalid_d;
        end
    end

    assign cpu_waitrequest   = (state_q == S_PEND);
    assign cpu_readdatavalid = cpu_rvalid_q;
    assign cpu_readdata      = cpu_rvalid_q ? ram_q : cpu_hold_q;
    assign jtag_rd_valid     = (state_q == S_RDWAIT);
    assign MonDReg           = (state_q == S_RDWAIT) ? ram_q : mon_d_q;
    assign MonAReg           = mon_a_q;
    assign jtag_overrun      = overrun_q;

endmodule

// File: tb/tb_nios_simple_cpu_ocimem_ctrl.sv
// tb/tb_nios_simple_cpu_ocimem_ctrl.sv - self-checking bench for the OCI debug memory controller
module tb_nios_simple_cpu_ocimem_ctrl;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [37:0]   jdo;
    logic          take_a, take_b, take_n;
    logic [AW-1:0] cpu_address;
    logic          cpu_read, cpu_write;
    logic [31:0]   cpu_writedata;
    logic [3:0]    cpu_byteenable;
    logic          cpu_waitrequest;
    logic [31:0]   cpu_readdata;
    logic          cpu_readdatavalid;
    logic [31:0]   MonDReg;
    logic [AW-1:0] MonAReg;
    logic          jtag_rd_valid;
    logic          jtag_overrun;

    logic [31:0]   model_mem [0:255];
    logic [7:0]    m_a;
    int            n_checks = 0;
    int            n_fail   = 0;

    nios_simple_cpu_ocimem_ctrl #(.ADDR_W(AW)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_action_ocimem_b    (take_b),
        .take_no_action_ocimem_a (take_n),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_byteenable          (cpu_byteenable),
        .cpu_waitrequest         (cpu_waitrequest),
        .cpu_readdata            (cpu_readdata),
        .cpu_readdatavalid       (cpu_readdatavalid),
        .MonDReg                 (MonDReg),
        .MonAReg                 (MonAReg),
        .jtag_rd_valid           (jtag_rd_valid),
        .jtag_overrun            (jtag_overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a(input logic [7:0] addr, input logic rd, input logic clr);
        jdo = '0;
        jdo[35] = clr;
        jdo[34] = rd;
        jdo[AW+16:17] = addr;
        take_a = 1'b1;
        step();
        take_a = 1'b0;
        jdo = '0;
    endtask

    task automatic pulse_b(input logic [31:0] data);
        jdo = {3'b000, data, 3'b000};
        take_b = 1'b1;
        step();
        take_b = 1'b0;
        jdo = '0;
    endtask

    task automatic pulse_n();
        take_n = 1'b1;
        step();
        take_n = 1'b0;
    endtask

    task automatic cpu_wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
        cpu_address = addr;
        cpu_writedata = data;
        cpu_byteenable = be;
        cpu_write = 1'b1;
        step();
        cpu_write = 1'b0;
    endtask

    function automatic void model_wr(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
        logic [31:0] w;
        w = model_mem[addr];
        for (int b = 0; b < 4; b++) begin
            if (be[b]) w[b*8 +: 8] = data[b*8 +: 8];
        end
        model_mem[addr] = w;
    endfunction

    task automatic test_reset();
        logic seen;
        reset = 1'b1;
        repeat (3) step();
        n_checks++; if (MonDReg !== 32'h0) begin n_fail++; $display("FAIL rst_mondreg got=%h exp=0", MonDReg); end
        n_checks++; if (MonAReg !== 8'h0) begin n_fail++; $display("FAIL rst_monareg got=%h exp=0", MonAReg); end
        n_checks++; if (jtag_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rdvalid got=%b exp=0", jtag_rd_valid); end
        n_checks++; if (jtag_overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun got=%b exp=0", jtag_overrun); end
        n_checks++; if (cpu_readdata !== 32'h0) begin n_fail++; $display("FAIL rst_cpurd got=%h exp=0", cpu_readdata); end
        n_checks++; if (cpu_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rst_cpurdv got=%b exp=0", cpu_readdatavalid); end
        n_checks++; if (cpu_waitrequest !== 1'b0) begin n_fail++; $display("FAIL rst_wait got=%b exp=0", cpu_waitrequest); end
        reset = 1'b0;
        step();
        // Reset asserted while a JTAG read is pending.
        pulse_a(8'h22, 1'b0, 1'b0);
        pulse_n();
        reset = 1'b1;
        #1;
        n_checks++; if (cpu_waitrequest !== 1'b0) begin n_fail++; $display("FAIL rstmid_wait got=%b exp=0", cpu_waitrequest); end
        n_checks++; if (MonAReg !== 8'h0) begin n_fail++; $display("FAIL rstmid_monareg got=%h exp=0", MonAReg); end
        step();
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (jtag_rd_valid !== 1'b0 || cpu_readdatavalid !== 1'b0) seen = 1'b1;
            step();
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_novalid got=%b exp=0", seen); end
        pulse_a(8'h33, 1'b0, 1'b0);
        n_checks++; if (MonAReg !== 8'h33) begin n_fail++; $display("FAIL rst_next_cmd got=%h exp=33", MonAReg); end
        step();
    endtask

    task automatic test_jtag_write_cpu_read();
        pulse_a(8'h10, 1'b0, 1'b0);
        step();
        pulse_b(32'hDEADBEEF);
        model_mem[8'h10] = 32'hDEADBEEF;
        m_a = 8'h11;
        n_checks++; if (cpu_waitrequest !== 1'b1) begin n_fail++; $display("FAIL jw_wait got=%b exp=1", cpu_waitrequest); end
        step();
        n_checks++; if (MonAReg !== m_a) begin n_fail++; $display("FAIL jw_monareg got=%h exp=%h", MonAReg, m_a); end
        n_checks++; if (jtag_rd_valid !== 1'b0) begin n_fail++; $display("FAIL jw_rdvalid got=%b exp=0", jtag_rd_valid); end
        cpu_address = 8'h10;
        cpu_read = 1'b1;
        step();
        cpu_read = 1'b0;
        n_checks++; if (cpu_readdatavalid !== 1'b1) begin n_fail++; $display("FAIL jw_cpurdv got=%b exp=1", cpu_readdatavalid); end
        n_checks++; if (cpu_readdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL jw_cpurd got=%h exp=deadbeef", cpu_readdata); end
        step();
        n_checks++; if (cpu_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL jw_cpurdv_once got=%b exp=0", cpu_readdatavalid); end
        n_checks++; if (cpu_readdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL jw_cpurd_hold got=%h exp=deadbeef", cpu_readdata); end
    endtask

    task automatic test_cpu_byte_write_wrap();
        cpu_wr(8'hFF, 32'h0, 4'hF);
        model_wr(8'hFF, 32'h0, 4'hF);
        cpu_wr(8'hFF, 32'h12345678, 4'b0011);
        model_wr(8'hFF, 32'h12345678, 4'b0011);
        step();
        pulse_a(8'hFF, 1'b1, 1'b0);
        n_checks++; if (jtag_rd_valid !== 1'b0) begin n_fail++; $display("FAIL bw_rdvalid_early got=%b exp=0", jtag_rd_valid); end
        step();
        n_checks++; if (MonDReg !== 32'h00005678) begin n_fail++; $display("FAIL bw_mondreg got=%h exp=00005678", MonDReg); end
        n_checks++; if (jtag_rd_valid !== 1'b1) begin n_fail++; $display("FAIL bw_rdvalid got=%b exp=1", jtag_rd_valid); end
        n_checks++; if (MonAReg !== 8'h00) begin n_fail++; $display("FAIL bw_wrap got=%h exp=00", MonAReg); end
        step();
        m_a = 8'h00;
        n_checks++; if (jtag_rd_valid !== 1'b0) begin n_fail++; $display("FAIL bw_rdvalid_once got=%b exp=0", jtag_rd_valid); end
        n_checks++; if (MonDReg !== model_mem[8'hFF]) begin n_fail++; $display("FAIL bw_mondreg_hold got=%h exp=%h", MonDReg, model_mem[8'hFF]); end
    endtask

    task automatic test_arbitration();
        pulse_a(8'h40, 1'b0, 1'b0);
        step();
        jdo = {3'b000, 32'hCAFEF00D, 3'b000};
        take_b = 1'b1;
        step();
        take_b = 1'b0;
        jdo = '0;
        model_mem[8'h40] = 32'hCAFEF00D;
        m_a = 8'h41;
        n_checks++; if (cpu_waitrequest !== 1'b1) begin n_fail++; $display("FAIL arb_wait_n1 got=%b exp=1", cpu_waitrequest); end
        cpu_address = 8'h40;
        cpu_read = 1'b1;
        step();
        n_checks++; if (cpu_waitrequest !== 1'b0) begin n_fail++; $display("FAIL arb_wait_n2 got=%b exp=0", cpu_waitrequest); end
        n_checks++; if (cpu_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL arb_rdv_n2 got=%b exp=0", cpu_readdatavalid); end
        step();
        cpu_read = 1'b0;
        n_checks++; if (cpu_readdatavalid !== 1'b1) begin n_fail++; $display("FAIL arb_rdv_n3 got=%b exp=1", cpu_readdatavalid); end
        n_checks++; if (cpu_readdata !== model_mem[8'h40]) begin n_fail++; $display("FAIL arb_rd_n3 got=%h exp=%h", cpu_readdata, model_mem[8'h40]); end
        step();
    endtask

    task automatic test_overrun();
        pulse_a(8'h10, 1'b0, 1'b0);
        step();
        take_n = 1'b1;
        step();
        n_checks++; if (cpu_waitrequest !== 1'b1) begin n_fail++; $display("FAIL ovr_wait got=%b exp=1", cpu_waitrequest); end
        step();
        take_n = 1'b0;
        n_checks++; if (jtag_rd_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_rdvalid got=%b exp=1", jtag_rd_valid); end
        n_checks++; if (MonDReg !== model_mem[8'h10]) begin n_fail++; $display("FAIL ovr_mondreg got=%h exp=%h", MonDReg, model_mem[8'h10]); end
        n_checks++; if (jtag_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set got=%b exp=1", jtag_overrun); end
        n_checks++; if (MonAReg !== 8'h11) begin n_fail++; $display("FAIL ovr_monareg got=%h exp=11", MonAReg); end
        step();
        n_checks++; if (jtag_rd_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_single got=%b exp=0", jtag_rd_valid); end
        pulse_a(8'h10, 1'b0, 1'b1);
        n_checks++; if (jtag_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got=%b exp=0", jtag_overrun); end
        n_checks++; if (MonAReg !== 8'h10) begin n_fail++; $display("FAIL ovr_clr_addr got=%h exp=10", MonAReg); end
        step();
    endtask

    task automatic test_simultaneous();
        jdo = {3'b000, 32'hA5A5A5A5, 3'b000};
        take_b = 1'b1;
        take_n = 1'b1;
        step();
        take_b = 1'b0;
        take_n = 1'b0;
        jdo = '0;
        model_mem[8'h10] = 32'hA5A5A5A5;
        n_checks++; if (jtag_overrun !== 1'b1) begin n_fail++; $display("FAIL sim_overrun got=%b exp=1", jtag_overrun); end
        n_checks++; if (cpu_waitrequest !== 1'b1) begin n_fail++; $display("FAIL sim_wait got=%b exp=1", cpu_waitrequest); end
        step();
        n_checks++; if (jtag_rd_valid !== 1'b0) begin n_fail++; $display("FAIL sim_rdvalid got=%b exp=0", jtag_rd_valid); end
        n_checks++; if (MonAReg !== 8'h11) begin n_fail++; $display("FAIL sim_monareg got=%h exp=11", MonAReg); end
        cpu_address = 8'h10;
        cpu_read = 1'b1;
        step();
        cpu_read = 1'b0;
        n_checks++; if (cpu_readdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL sim_write got=%h exp=a5a5a5a5", cpu_readdata); end
        pulse_a(8'h10, 1'b0, 1'b1);
        n_checks++; if (jtag_overrun !== 1'b0) begin n_fail++; $display("FAIL sim_clear got=%b exp=0", jtag_overrun); end
        step();
    endtask

    task automatic test_back_to_back();
        cpu_wr(8'h11, 32'h0BADCAFE, 4'hF);
        model_wr(8'h11, 32'h0BADCAFE, 4'hF);
        pulse_a(8'h10, 1'b1, 1'b0);
        step();
        n_checks++; if (jtag_rd_valid !== 1'b1 || MonDReg !== model_mem[8'h10]) begin n_fail++; $display("FAIL b2b_first got=%b/%h exp=1/%h", jtag_rd_valid, MonDReg, model_mem[8'h10]); end
        pulse_n();
        n_checks++; if (cpu_waitrequest !== 1'b1 || jtag_rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_pend got=%b/%b exp=1/0", cpu_waitrequest, jtag_rd_valid); end
        step();
        n_checks++; if (jtag_rd_valid !== 1'b1 || MonDReg !== 32'h0BADCAFE) begin n_fail++; $display("FAIL b2b_second got=%b/%h exp=1/0badcafe", jtag_rd_valid, MonDReg); end
        n_checks++; if (MonAReg !== 8'h12 || jtag_overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_state got=%h/%b exp=12/0", MonAReg, jtag_overrun); end
        m_a = 8'h12;
        step();
    endtask

    task automatic test_random();
        logic [7:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
        logic        rd;
        for (int i = 0; i < 256; i++) begin
            d = $urandom;
            cpu_wr(8'(i), d, 4'hF);
            model_wr(8'(i), d, 4'hF);
        end
        step();
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 4))
                0: begin
                    a  = 8'($urandom);
                    rd = 1'($urandom);
                    pulse_a(a, rd, 1'b1);
                    m_a = a;
                    if (rd) begin
                        step();
                        n_checks++; if (jtag_rd_valid !== 1'b1 || MonDReg !== model_mem[a]) begin n_fail++; $display("FAIL rnd_aread it=%0d got=%b/%h exp=1/%h", it, jtag_rd_valid, MonDReg, model_mem[a]); end
                        m_a = a + 8'd1;
                    end
                    n_checks++; if (MonAReg !== m_a) begin n_fail++; $display("FAIL rnd_aaddr it=%0d got=%h exp=%h", it, MonAReg, m_a); end
                end
                1: begin
                    d = $urandom;
                    pulse_b(d);
                    step();
                    model_mem[m_a] = d;
                    m_a = m_a + 8'd1;
                    n_checks++; if (MonAReg !== m_a || jtag_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_bwrite it=%0d got=%h/%b exp=%h/0", it, MonAReg, jtag_rd_valid, m_a); end
                end
                2: begin
                    pulse_n();
                    step();
                    n_checks++; if (jtag_rd_valid !== 1'b1 || MonDReg !== model_mem[m_a]) begin n_fail++; $display("FAIL rnd_nread it=%0d got=%b/%h exp=1/%h", it, jtag_rd_valid, MonDReg, model_mem[m_a]); end
                    m_a = m_a + 8'd1;
                    n_checks++; if (MonAReg !== m_a) begin n_fail++; $display("FAIL rnd_naddr it=%0d got=%h exp=%h", it, MonAReg, m_a); end
                end
                3: begin
                    a  = 8'($urandom);
                    d  = $urandom;
                    be = 4'($urandom);
                    cpu_wr(a, d, be);
                    model_wr(a, d, be);
                end
                default: begin
                    a = 8'($urandom);
                    cpu_address = a;
                    cpu_read = 1'b1;
                    step();
                    cpu_read = 1'b0;
                    n_checks++; if (cpu_readdatavalid !== 1'b1 || cpu_readdata !== model_mem[a]) begin n_fail++; $display("FAIL rnd_cread it=%0d got=%b/%h exp=1/%h", it, cpu_readdatavalid, cpu_readdata, model_mem[a]); end
                end
            endcase
            if ($urandom_range(0, 1) == 1) step();
        end
        n_checks++; if (jtag_overrun !== 1'b0) begin n_fail++; $display("FAIL rnd_overrun got=%b exp=0", jtag_overrun); end
    endtask

    initial begin
        reset = 1'b1;
        jdo = '0;
        take_a = 1'b0;
        take_b = 1'b0;
        take_n = 1'b0;
        cpu_address = '0;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        cpu_writedata = '0;
        cpu_byteenable = '0;
        m_a = '0;
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        test_reset();
        test_jtag_write_cpu_read();
        test_cpu_byte_write_wrap();
        test_arbitration();
        test_overrun();
        test_simultaneous();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nios_simple_cpu_ocimem_ctrl.md
# nios_simple_cpu_ocimem_ctrl

On-chip debug memory controller for the Nios II OCI, in the system-clock domain. It sits directly downstream of the JTAG debug module's sysclk stage, consuming `jdo` and the `take_*_ocimem_*` command pulses. It arbitrates a single-port debug RAM between the JTAG host and the CPU's debug slave port. It returns JTAG read data on `MonDReg`, which feeds back into the JTAG debug wrapper's `MonDReg` input.

## Interface
Parameters:
- `ADDR_W`, default 8: RAM word-address width; depth is 2^ADDR_W × 32 bits; legal range 4..16.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `jdo`  in  38  JTAG data from the sysclk stage; valid while a command pulse is high.
- `take_action_ocimem_a`  in  1  one-cycle pulse: load address; optionally read and/or clear overrun.
- `take_action_ocimem_b`  in  1  one-cycle pulse: write a word.
- `take_no_action_ocimem_a`  in  1  one-cycle pulse: streaming read.
- `cpu_address`  in  ADDR_W  CPU word address.
- `cpu_read`  in  1  CPU read request.
- `cpu_write`  in  1  CPU write request.
- `cpu_writedata`  in  32  CPU write data.
- `cpu_byteenable`  in  4  CPU byte enables.
- `cpu_waitrequest`  out  1  request not accepted this cycle.
- `cpu_readdata`  out  32  CPU read data.
- `cpu_readdatavalid`  out  1  `cpu_readdata` valid.
- `MonDReg`  out  32  last JTAG read data.
- `MonAReg`  out  ADDR_W  next JTAG access address.
- `jtag_rd_valid`  out  1  one-cycle pulse when `MonDReg` updates.
- `jtag_overrun`  out  1  sticky flag: a JTAG command was dropped.

## Operation
- **RAM:** 2^ADDR_W × 32, single port, one access per cycle, registered read (1-cycle latency). Contents are not reset.
- **JTAG command decode** (on the cycle a pulse is high):
  - `take_action_ocimem_a`: `MonAReg` <= `jdo[ADDR_W+16:17]`. If `jdo[35]`, clear `jtag_overrun`. If `jdo[34]`, queue a READ at the new address.
  - `take_action_ocimem_b`: queue a WRITE of `jdo[34:3]` at `MonAReg`, all bytes enabled.
  - `take_no_action_ocimem_a`: queue a READ at `MonAReg`.
  - Simultaneous pulses: priority is `_b` > `action_a` > `no_action_a`. Losing pulses are ignored and set `jtag_overrun`.
- **One-deep command slot; FSM states IDLE, PEND, RDWAIT:**
  - IDLE: a queued command is captured; next state is PEND.
  - PEND: JTAG owns the RAM and executes the command. After execution, `MonAReg` <= `MonAReg + 1`, wrapping from 2^ADDR_W−1 to 0. Next state is RDWAIT for a READ, IDLE for a WRITE.
  - RDWAIT: `MonDReg` <= RAM output and `jtag_rd_valid` = 1. A command arriving in this cycle is captured (next state PEND); otherwise next state is IDLE.
  - A command arriving while in PEND is dropped and `jtag_overrun` is set. An address load from a dropped `action_a` does not occur.
- **CPU arbitration:**
  - `cpu_waitrequest` = (state == PEND), combinational. JTAG always wins.
  - When not in PEND, a `cpu_read` or `cpu_write` is accepted. Writes honour `cpu_byteenable`.
  - `cpu_read` and `cpu_write` high together: the write is performed and no readdatavalid is produced.
  - Accepted read: `cpu_readdata` is updated and `cpu_readdatavalid` = 1 exactly one cycle later. `cpu_readdata` holds its value otherwise.

## Timing
- **Reset values:** `MonDReg`=0, `MonAReg`=0, `jtag_rd_valid`=0, `jtag_overrun`=0, `cpu_readdata`=0, `cpu_readdatavalid`=0, `cpu_waitrequest`=0, FSM=IDLE, slot empty.
- **JTAG latency:** pulse at cycle N → RAM access at N+1 → `MonDReg`/`jtag_rd_valid` at N+2. `MonAReg` shows the incremented value from N+2.
- **CPU stall:** the CPU is stalled for exactly one cycle (N+1) per JTAG command. A CPU read accepted at N+2 observes a JTAG write made at N+1.
- **Reset mid-operation:** the pending command is discarded and no `jtag_rd_valid` or `cpu_readdatavalid` is emitted. A write executing in the cycle reset asserts may or may not be committed.
- **Command spacing:** the upstream sysclk stage spaces commands by at least 2 cycles in normal operation. Closer spacing is handled only via the overrun rule.

## Test plan
- **Reset:** assert `reset` mid-sequence → all outputs at their reset values; next command is decoded from IDLE.
- **JTAG write, CPU readback:** `action_a` with `jdo[24:17]`=0x10, `jdo[34]`=0; then `action_b` with data 0xDEADBEEF → `MonAReg`=0x11; CPU read of 0x10 → `cpu_readdata`=0xDEADBEEF one cycle after acceptance.
- **CPU byte write, JTAG read with wrap:** CPU writes 0x12345678 to 0xFF with be=4'b0011 over 0 → `action_a` addr 0xFF, `jdo[34]`=1 → at N+2 `MonDReg`=0x00005678, `jtag_rd_valid` pulses once, `MonAReg`=0x00.
- **Arbitration:** CPU read held high across a JTAG command at N → `cpu_waitrequest`=1 only at N+1; read accepted at N+2; `cpu_readdatavalid` at N+3.
- **Overrun:** `no_action_a` at N and N+1 → second dropped, one `jtag_rd_valid`, `jtag_overrun`=1; `action_a` with `jdo[35]`=1 → `jtag_overrun`=0.
- **Simultaneous pulses:** `action_b` (data 0xA5A5A5A5) and `no_action_a` in the same cycle → write performed at `MonAReg`, no `jtag_rd_valid`, `jtag_overrun`=1.
